// File: rtl/lcd_show_char_if.sv
// ---------------------------------------------------------------------------
// lcd_show_char_if
// Groups the two buses the character renderer talks over:
//   - SPI byte-writer port: spi_wr_req / spi_wr_data (out), spi_wr_ack (in)
//   - font ROM port:        rom_addr / rom_sel (out), rom_data (in, 1-cycle latency)
//   - state_dbg:            current renderer FSM state for checkers
//                           (IDLE=0, SET_WIN=1, FETCH=2, WAIT_ROM=3,
//                            PIX_HI=4, PIX_LO=5, DONE=6)
//
// Byte-write handshake: the master raises spi_wr_req in the same cycle that
// spi_wr_data becomes valid and holds both stable until it samples
// spi_wr_ack=1 at a clock edge. spi_wr_req is low in the following cycle,
// and the next request rises no earlier than the cycle after that drop.
// spi_wr_ack is a single-cycle pulse from the writer.
//
// master: the renderer (lcd_show_char). slave: the SPI writer / font ROM side.
// ---------------------------------------------------------------------------
interface lcd_show_char_if;
   logic        spi_wr_req;
   logic [8:0]  spi_wr_data;
   logic        spi_wr_ack;
   logic [10:0] rom_addr;
   logic        rom_sel;
   logic [7:0]  rom_data;
   logic [2:0]  state_dbg;

   modport master (
      output spi_wr_req,
      output spi_wr_data,
      input  spi_wr_ack,
      output rom_addr,
      output rom_sel,
      input  rom_data,
      output state_dbg
   );

   modport slave (
      input  spi_wr_req,
      input  spi_wr_data,
      output spi_wr_ack,
      input  rom_addr,
      input  rom_sel,
      output rom_data,
      input  state_dbg
   );
endinterface

// File: rtl/lcd_show_char.sv
// ---------------------------------------------------------------------------
// lcd_show_char
// Draws one font character on an RGB565 LCD through an SPI byte writer.
// On a one-cycle show_char_flag in IDLE it latches the character, position,
// font size and colours, programs the panel window (CASET 0x2A, RASET 0x2B,
// RAMWR 0x2C) and then streams W*H pixels, two data bytes per pixel, reading
// one font row per text row from an external ROM.
//
// Ports:
//   sys_clk, sys_rst_n     single clock, synchronous active-low reset
//   show_char_flag         one-cycle draw request (ignored while busy)
//   ascii_num              font index (ASCII-32), values >94 draw a space
//   start_x, start_y       top-left pixel of the character
//   en_size                1 = 16x8 font, 0 = 12x6 font
//   background_color       colour for 0 bits
//   front_color            colour for 1 bits
//   busy                   high from the cycle after acceptance until done
//   show_char_done         one-cycle pulse when the character is finished
//   lcd_bus (master)       SPI byte-writer and font ROM buses, FSM state
// ---------------------------------------------------------------------------
module lcd_show_char #(
   parameter int H_RES = 160,
   parameter int V_RES = 128
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              show_char_flag,
   input  logic [6:0]        ascii_num,
   input  logic [8:0]        start_x,
   input  logic [8:0]        start_y,
   input  logic              en_size,
   input  logic [15:0]       background_color,
   input  logic [15:0]       front_color,
   output logic              busy,
   output logic              show_char_done,
   lcd_show_char_if.master   lcd_bus
);

   localparam logic [8:0] H_LIM = 9'(H_RES);
   localparam logic [8:0] V_LIM = 9'(V_RES);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SET_WIN  = 3'd1,
      FETCH    = 3'd2,
      WAIT_ROM = 3'd3,
      PIX_HI   = 3'd4,
      PIX_LO   = 3'd5,
      DONE     = 3'd6
   } state_t;

   state_t      state_q, state_d;

   // Latched character request
   logic [6:0]  ascii_q, ascii_d;
   logic [8:0]  xs_q, xs_d;
   logic [8:0]  ys_q, ys_d;
   logic [8:0]  xe_q, xe_d;
   logic [8:0]  ye_q, ye_d;
   logic        en_q, en_d;
   logic [15:0] bg_q, bg_d;
   logic [15:0] fg_q, fg_d;
   logic        oob_q, oob_d;

   // Progress counters and the current font row
   logic [3:0]  win_idx_q, win_idx_d;
   logic [3:0]  row_q, row_d;
   logic [2:0]  col_q, col_d;
   logic [7:0]  row_sr_q, row_sr_d;

   // Byte-writer request registers
   logic        req_q, req_d;
   logic [8:0]  data_q, data_d;

   logic        acked;
   logic        send_en;
   logic [2:0]  last_col;
   logic [3:0]  last_row;
   logic [15:0] pix_color;
   logic [8:0]  win_byte;
   logic [8:0]  cur_byte;
   logic [10:0] rom_base;

   // Geometry of the latched font
   assign last_col = en_q ? 3'd7  : 3'd5;
   assign last_row = en_q ? 4'd15 : 4'd11;

   // The row register is shifted left after each pixel, so bit 7 is always
   // the pixel being sent.
   assign pix_color = row_sr_q[7] ? fg_q : bg_q;

   // ascii*16 for the large font, ascii*12 = ascii*8 + ascii*4 for the small one
   assign rom_base = en_q ? {ascii_q, 4'b0000}
                          : ({1'b0, ascii_q, 3'b000} + {2'b00, ascii_q, 2'b00});

   assign acked = req_q & lcd_bus.spi_wr_ack;

   // An out-of-range start sits in SET_WIN for one cycle without sending.
   assign send_en = ((state_q == SET_WIN) && !oob_q) ||
                    (state_q == PIX_HI) || (state_q == PIX_LO);

   // Window programming sequence: bit 8 is D/C (0 = command, 1 = data)
   always_comb begin
      win_byte = 9'h000;
      case (win_idx_q)
         4'd0:    win_byte = {1'b0, 8'h2A};
         4'd1:    win_byte = {1'b1, 7'd0, xs_q[8]};
         4'd2:    win_byte = {1'b1, xs_q[7:0]};
         4'd3:    win_byte = {1'b1, 7'd0, xe_q[8]};
         4'd4:    win_byte = {1'b1, xe_q[7:0]};
         4'd5:    win_byte = {1'b0, 8'h2B};
         4'd6:    win_byte = {1'b1, 7'd0, ys_q[8]};
         4'd7:    win_byte = {1'b1, ys_q[7:0]};
         4'd8:    win_byte = {1'b1, 7'd0, ye_q[8]};
         4'd9:    win_byte = {1'b1, ye_q[7:0]};
         4'd10:   win_byte = {1'b0, 8'h2C};
         default: win_byte = 9'h000;
      endcase
   end

   always_comb begin
      cur_byte = 9'h000;
      case (state_q)
         SET_WIN: cur_byte = win_byte;
         PIX_HI:  cur_byte = {1'b1, pix_color[15:8]};
         PIX_LO:  cur_byte = {1'b1, pix_color[7:0]};
         default: cur_byte = 9'h000;
      endcase
   end

   // Next-state and datapath
   always_comb begin
      state_d   = state_q;
      ascii_d   = ascii_q;
      xs_d      = xs_q;
      ys_d      = ys_q;
      xe_d      = xe_q;
      ye_d      = ye_q;
      en_d      = en_q;
      bg_d      = bg_q;
      fg_d      = fg_q;
      oob_d     = oob_q;
      win_idx_d = win_idx_q;
      row_d     = row_q;
      col_d     = col_q;
      row_sr_d  = row_sr_q;
      req_d     = req_q;
      data_d    = data_q;

      // Request generation. A request only rises while req_q is low, which
      // leaves the required idle cycle after every acknowledged byte.
      if (acked) begin
         req_d = 1'b0;
      end else if (!req_q && send_en) begin
         req_d  = 1'b1;
         data_d = cur_byte;
      end

      case (state_q)
         IDLE: begin
            if (show_char_flag) begin
               ascii_d   = (ascii_num > 7'd94) ? 7'd0 : ascii_num;
               xs_d      = start_x;
               ys_d      = start_y;
               // 9-bit sums: the window end may run past the panel unclipped
               xe_d      = start_x + (en_size ? 9'd7  : 9'd5);
               ye_d      = start_y + (en_size ? 9'd15 : 9'd11);
               en_d      = en_size;
               bg_d      = background_color;
               fg_d      = front_color;
               oob_d     = (start_x >= H_LIM) || (start_y >= V_LIM);
               win_idx_d = 4'd0;
               row_d     = 4'd0;
               col_d     = 3'd0;
               state_d   = SET_WIN;
            end
         end

         SET_WIN: begin
            if (oob_q) begin
               state_d = DONE;
            end else if (acked) begin
               if (win_idx_q == 4'd10) begin
                  row_d   = 4'd0;
                  state_d = FETCH;
               end else begin
                  win_idx_d = win_idx_q + 4'd1;
               end
            end
         end

         // rom_addr is valid here; the ROM answers one cycle later
         FETCH: begin
            state_d = WAIT_ROM;
         end

         WAIT_ROM: begin
            row_sr_d = lcd_bus.rom_data;
            col_d    = 3'd0;
            state_d  = PIX_HI;
         end

         PIX_HI: begin
            if (acked) begin
               state_d = PIX_LO;
            end
         end

         PIX_LO: begin
            if (acked) begin
               if (col_q == last_col) begin
                  if (row_q == last_row) begin
                     state_d = DONE;
                  end else begin
                     row_d   = row_q + 4'd1;
                     state_d = FETCH;
                  end
               end else begin
                  col_d    = col_q + 3'd1;
                  row_sr_d = {row_sr_q[6:0], 1'b0};
                  state_d  = PIX_HI;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         ascii_q   <= 7'd0;
         xs_q      <= 9'd0;
         ys_q      <= 9'd0;
         xe_q      <= 9'd0;
         ye_q      <= 9'd0;
         en_q      <= 1'b0;
         bg_q      <= 16'h0000;
         fg_q      <= 16'h0000;
         oob_q     <= 1'b0;
         win_idx_q <= 4'd0;
         row_q     <= 4'd0;
         col_q     <= 3'd0;
         row_sr_q  <= 8'h00;
         req_q     <= 1'b0;
         data_q    <= 9'h000;
      end else begin
         state_q   <= state_d;
         ascii_q   <= ascii_d;
         xs_q      <= xs_d;
         ys_q      <= ys_d;
         xe_q      <= xe_d;
         ye_q      <= ye_d;
         en_q      <= en_d;
         bg_q      <= bg_d;
         fg_q      <= fg_d;
         oob_q     <= oob_d;
         win_idx_q <= win_idx_d;
         row_q     <= row_d;
         col_q     <= col_d;
         row_sr_q  <= row_sr_d;
         req_q     <= req_d;
         data_q    <= data_d;
      end
   end

   // DONE lasts exactly one cycle, so the done pulse and the busy drop
   // coincide, and IDLE follows immediately.
   assign busy           = (state_q != IDLE) && (state_q != DONE);
   assign show_char_done = (state_q == DONE);

   assign lcd_bus.spi_wr_req  = req_q;
   assign lcd_bus.spi_wr_data = data_q;
   assign lcd_bus.rom_addr    = rom_base + {7'd0, row_q};
   assign lcd_bus.rom_sel     = en_q;
   assign lcd_bus.state_dbg   = state_q;

endmodule

// File: tb/tb_lcd_show_char.sv
// ---------------------------------------------------------------------------
// tb_lcd_show_char
// Self-checking bench for lcd_show_char: table of directed characters, a few
// hand sequences (ignored second request, reset mid-character, back-to-back
// requests) and random characters, all checked against a behavioural model
// that builds the expected byte stream and ROM address list from the font
// geometry rules.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_show_char;

   localparam int H_RES = 160;
   localparam int V_RES = 128;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd2;

   // ---------------- clock / reset ----------------
   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic        show_char_flag;
   logic [6:0]  ascii_num;
   logic [8:0]  start_x;
   logic [8:0]  start_y;
   logic        en_size;
   logic [15:0] background_color;
   logic [15:0] front_color;
   logic        busy;
   logic        show_char_done;

   lcd_show_char_if lcd_bus ();

   lcd_show_char #(.H_RES(H_RES), .V_RES(V_RES)) dut (
      .sys_clk          (sys_clk),
      .sys_rst_n        (sys_rst_n),
      .show_char_flag   (show_char_flag),
      .ascii_num        (ascii_num),
      .start_x          (start_x),
      .start_y          (start_y),
      .en_size          (en_size),
      .background_color (background_color),
      .front_color      (front_color),
      .busy             (busy),
      .show_char_done   (show_char_done),
      .lcd_bus          (lcd_bus)
   );

   // ---------------- font ROM model (1-cycle latency) ----------------
   logic [7:0] rom16 [0:2047];
   logic [7:0] rom12 [0:2047];
   always @(posedge sys_clk)
      lcd_bus.rom_data <= lcd_bus.rom_sel ? rom16[lcd_bus.rom_addr] : rom12[lcd_bus.rom_addr];

   // ---------------- scoreboard state ----------------
   logic [8:0]  exp_q[$];
   logic [8:0]  got_q[$];
   logic [10:0] exp_addr_q[$];
   logic [10:0] got_addr_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int proto_err = 0;
   int last_ack_cyc = 0;
   int ack_dly = 3;

   // ---------------- SPI writer model + bus monitor ----------------
   logic       prev_req = 1'b0;
   logic       prev_ack = 1'b0;
   logic [8:0] prev_data = 9'h000;
   int         age = 0;
   always @(negedge sys_clk) begin
      logic ack_v;
      ack_v = 1'b0;
      if (sys_rst_n) begin
         // request must hold with stable data until acknowledged
         if (prev_req && !prev_ack &&
             (!lcd_bus.spi_wr_req || lcd_bus.spi_wr_data != prev_data)) proto_err++;
         // request must be low in the cycle after the acknowledge
         if (prev_req && prev_ack && lcd_bus.spi_wr_req) proto_err++;
         if (lcd_bus.spi_wr_req) begin
            if (!prev_req || prev_ack) age = 0;
            else age++;
            if (age == ack_dly) begin
               ack_v = 1'b1;
               got_q.push_back(lcd_bus.spi_wr_data);
               last_ack_cyc = cyc;
            end
         end
         if (lcd_bus.state_dbg == ST_FETCH) got_addr_q.push_back(lcd_bus.rom_addr);
         if (show_char_done) done_cnt++;
      end
      lcd_bus.spi_wr_ack = ack_v;
      prev_req  = sys_rst_n ? lcd_bus.spi_wr_req : 1'b0;
      prev_ack  = ack_v;
      prev_data = lcd_bus.spi_wr_data;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: expected byte stream and ROM addresses of one character
   task automatic build_expected(input logic [6:0] a_in, input logic [8:0] x, input logic [8:0] y,
                                 input logic en, input logic [15:0] bg, input logic [15:0] fg);
      int a, w, h, addr;
      logic [8:0]  xe, ye;
      logic [7:0]  rb;
      logic [15:0] col;
      exp_q.delete();
      exp_addr_q.delete();
      a = (a_in > 7'd94) ? 0 : int'(a_in);
      w = en ? 8 : 6;
      h = en ? 16 : 12;
      if (int'(x) >= H_RES || int'(y) >= V_RES) return;
      xe = 9'((int'(x) + w - 1) % 512);
      ye = 9'((int'(y) + h - 1) % 512);
      exp_q.push_back({1'b0, 8'h2A});
      exp_q.push_back({1'b1, 7'd0, x[8]});
      exp_q.push_back({1'b1, x[7:0]});
      exp_q.push_back({1'b1, 7'd0, xe[8]});
      exp_q.push_back({1'b1, xe[7:0]});
      exp_q.push_back({1'b0, 8'h2B});
      exp_q.push_back({1'b1, 7'd0, y[8]});
      exp_q.push_back({1'b1, y[7:0]});
      exp_q.push_back({1'b1, 7'd0, ye[8]});
      exp_q.push_back({1'b1, ye[7:0]});
      exp_q.push_back({1'b0, 8'h2C});
      for (int r = 0; r < h; r++) begin
         addr = a * h + r;
         exp_addr_q.push_back(11'(addr));
         rb = en ? rom16[addr] : rom12[addr];
         for (int c = 0; c < w; c++) begin
            col = rb[7 - c] ? fg : bg;
            exp_q.push_back({1'b1, col[15:8]});
            exp_q.push_back({1'b1, col[7:0]});
         end
      end
   endtask

   typedef struct {
      logic [6:0]  ascii;
      logic [8:0]  x;
      logic [8:0]  y;
      logic        en;
      logic [15:0] bg;
      logic [15:0] fg;
      int          dly;
      int          exp_total;   // -1: not given
      int          exp_addr0;   // -1: not given
      logic        chk_win;
      logic [87:0] exp_win;
      logic        chk_px;
      logic [31:0] exp_px;
   } vec_t;

   function automatic vec_t mk(input logic [6:0] a, input logic [8:0] x, input logic [8:0] y,
                               input logic en, input logic [15:0] bg, input logic [15:0] fg,
                               input int dly, input int tot, input int a0,
                               input logic cw, input logic [87:0] w,
                               input logic cp, input logic [31:0] p);
      vec_t v;
      v.ascii = a; v.x = x; v.y = y; v.en = en; v.bg = bg; v.fg = fg; v.dly = dly;
      v.exp_total = tot; v.exp_addr0 = a0;
      v.chk_win = cw; v.exp_win = w; v.chk_px = cp; v.exp_px = p;
      return v;
   endfunction

   // Drive one request and check the whole character.
   task automatic run_char(input vec_t v, input int idx, input bit inject, input bit immediate);
      int c0, n, nbad, bad_i, exp_done;
      bit seen_done;
      logic [87:0] win;
      logic [31:0] px;
      build_expected(v.ascii, v.x, v.y, v.en, v.bg, v.fg);
      if (!immediate) @(negedge sys_clk);
      got_q.delete();
      got_addr_q.delete();
      done_cnt  = 0;
      proto_err = 0;
      ack_dly   = v.dly;
      ascii_num = v.ascii; start_x = v.x; start_y = v.y; en_size = v.en;
      background_color = v.bg; front_color = v.fg;
      show_char_flag = 1'b1;
      c0 = cyc;
      @(negedge sys_clk);
      show_char_flag = 1'b0;
      // change the live inputs: only the latched copy may be used
      ascii_num = 7'($urandom_range(0, 127));
      start_x = 9'($urandom_range(0, 511));
      start_y = 9'($urandom_range(0, 511));
      en_size = ~v.en;
      background_color = 16'($urandom);
      front_color = 16'($urandom);
      check($sformatf("v%0d busy_rise", idx), {63'd0, busy}, 64'd1);

      seen_done = 1'b0;
      n = 0;
      while (!seen_done && n < 6000) begin
         if (show_char_done) seen_done = 1'b1;
         else begin
            show_char_flag = (inject && n == 60);
            @(negedge sys_clk);
            n++;
         end
      end
      show_char_flag = 1'b0;
      check($sformatf("v%0d done_seen", idx), {63'd0, seen_done}, 64'd1);
      if (seen_done) begin
         exp_done = (exp_q.size() == 0) ? c0 + 2 : last_ack_cyc + 1;
         check($sformatf("v%0d done_cycle", idx), 64'(cyc), 64'(exp_done));
         check($sformatf("v%0d busy_at_done", idx), {63'd0, busy}, 64'd0);
      end else begin
         sys_rst_n = 1'b0;
         @(negedge sys_clk);
         sys_rst_n = 1'b1;
      end
      @(negedge sys_clk);
      check($sformatf("v%0d done_width", idx), {63'd0, show_char_done}, 64'd0);
      check($sformatf("v%0d done_count", idx), 64'(done_cnt), 64'd1);
      check($sformatf("v%0d protocol_errors", idx), 64'(proto_err), 64'd0);

      check($sformatf("v%0d byte_count", idx), 64'(got_q.size()), 64'(exp_q.size()));
      nbad = 0; bad_i = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin
            nbad++;
            if (bad_i < 0) bad_i = i;
         end
      if (bad_i >= 0)
         check($sformatf("v%0d bytes (first bad #%0d got %0h exp %0h)", idx, bad_i,
                         got_q[bad_i], exp_q[bad_i]), 64'(nbad), 64'd0);
      else
         check($sformatf("v%0d bytes", idx), 64'(nbad), 64'd0);

      nbad = 0;
      for (int i = 0; i < got_addr_q.size() && i < exp_addr_q.size(); i++)
         if (got_addr_q[i] !== exp_addr_q[i]) nbad++;
      check($sformatf("v%0d rom_addr_count", idx), 64'(got_addr_q.size()), 64'(exp_addr_q.size()));
      check($sformatf("v%0d rom_addr_values", idx), 64'(nbad), 64'd0);

      if (v.exp_total >= 0)
         check($sformatf("v%0d total_bytes", idx), 64'(got_q.size()), 64'(v.exp_total));
      if (v.exp_addr0 >= 0)
         check($sformatf("v%0d rom_addr_first", idx),
               (got_addr_q.size() > 0) ? 64'(got_addr_q[0]) : 64'hFFFF, 64'(v.exp_addr0));
      if (v.chk_win) begin
         win = '0;
         for (int i = 0; i < 11; i++)
            win = {win[79:0], (i < got_q.size()) ? got_q[i][7:0] : 8'h00};
         check($sformatf("v%0d window_bytes", idx), 64'(win[87:64]), 64'(v.exp_win[87:64]));
         check($sformatf("v%0d window_bytes_lo", idx), win[63:0], v.exp_win[63:0]);
      end
      if (v.chk_px) begin
         px = '0;
         for (int i = 11; i < 15; i++)
            px = {px[23:0], (i < got_q.size()) ? got_q[i][7:0] : 8'h00};
         check($sformatf("v%0d first_pixels", idx), 64'(px), 64'(v.exp_px));
      end
   endtask

   // ---------------- test ----------------
   vec_t tbl[8];

   initial begin
      int n;
      vec_t rv;
      show_char_flag = 1'b0; ascii_num = 7'd0; start_x = 9'd0; start_y = 9'd0;
      en_size = 1'b0; background_color = 16'h0000; front_color = 16'h0000;

      for (int i = 0; i < 2048; i++) begin
         rom16[i] = 8'($urandom_range(0, 255));
         rom12[i] = 8'($urandom_range(0, 255));
      end
      rom16[528] = 8'hA0;

      //            ascii  x       y       en    bg        fg        dly tot  addr0 win  exp_win                              px   exp_px
      tbl[0] = mk(7'd43,  9'd48,  9'd0,   1'b1, 16'h001F, 16'hF800, 3,  267, 688,  1'b1, 88'h2A_00_30_00_37_2B_00_00_00_0F_2C, 1'b0, 32'h0);
      tbl[1] = mk(7'd17,  9'd0,   9'd32,  1'b0, 16'h1234, 16'hABCD, 1,  155, 204,  1'b1, 88'h2A_00_00_00_05_2B_00_20_00_2B_2C, 1'b0, 32'h0);
      tbl[2] = mk(7'd33,  9'd10,  9'd10,  1'b1, 16'hAF7D, 16'hFFFF, 0,  267, 528,  1'b1, 88'h2A_00_0A_00_11_2B_00_0A_00_19_2C, 1'b1, 32'hFFFF_AF7D);
      tbl[3] = mk(7'd5,   9'd160, 9'd0,   1'b1, 16'h0000, 16'hFFFF, 2,  0,   -1,   1'b0, 88'h0,                                1'b0, 32'h0);
      tbl[4] = mk(7'd5,   9'd0,   9'd128, 1'b0, 16'h0000, 16'hFFFF, 2,  0,   -1,   1'b0, 88'h0,                                1'b0, 32'h0);
      tbl[5] = mk(7'd94,  9'd156, 9'd120, 1'b1, 16'h07E0, 16'hF81F, 2,  267, 1504, 1'b1, 88'h2A_00_9C_00_A3_2B_00_78_00_87_2C, 1'b0, 32'h0);
      tbl[6] = mk(7'd100, 9'd100, 9'd0,   1'b0, 16'h5555, 16'hAAAA, 1,  155, 0,    1'b1, 88'h2A_00_64_00_69_2B_00_00_00_0B_2C, 1'b0, 32'h0);
      tbl[7] = mk(7'd1,   9'd159, 9'd127, 1'b0, 16'h0F0F, 16'hF0F0, 0,  155, 12,   1'b1, 88'h2A_00_9F_00_A4_2B_00_7F_00_8A_2C, 1'b0, 32'h0);

      // reset state
      repeat (3) @(negedge sys_clk);
      check("reset_outputs",
            {57'd0, busy, show_char_done, lcd_bus.spi_wr_req, lcd_bus.rom_sel, lcd_bus.state_dbg},
            {57'd0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE});
      check("reset_data_addr", {44'd0, lcd_bus.spi_wr_data, lcd_bus.rom_addr}, 64'd0);
      sys_rst_n = 1'b1;

      // directed table; entry 2 is issued the cycle after entry 1's done pulse
      for (int i = 0; i < 8; i++)
         run_char(tbl[i], i, 1'b0, i == 2);

      // second request mid-character must be ignored
      run_char(tbl[0], 100, 1'b1, 1'b0);

      // reset asserted around byte 100
      build_expected(tbl[0].ascii, tbl[0].x, tbl[0].y, tbl[0].en, tbl[0].bg, tbl[0].fg);
      @(negedge sys_clk);
      got_q.delete(); done_cnt = 0; ack_dly = 1;
      ascii_num = tbl[0].ascii; start_x = tbl[0].x; start_y = tbl[0].y; en_size = tbl[0].en;
      background_color = tbl[0].bg; front_color = tbl[0].fg;
      show_char_flag = 1'b1;
      @(negedge sys_clk);
      show_char_flag = 1'b0;
      n = 0;
      while (got_q.size() < 100 && n < 3000) begin
         @(negedge sys_clk);
         n++;
      end
      check("reset_mid reached byte 100", {63'd0, got_q.size() >= 100}, 64'd1);
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      check("reset_mid outputs",
            {57'd0, busy, show_char_done, lcd_bus.spi_wr_req, lcd_bus.rom_sel, lcd_bus.state_dbg},
            {57'd0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE});
      check("reset_mid data_addr", {44'd0, lcd_bus.spi_wr_data, lcd_bus.rom_addr}, 64'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (6) @(negedge sys_clk);
      check("reset_mid no_done", 64'(done_cnt), 64'd0);
      run_char(tbl[0], 101, 1'b0, 1'b0);

      // random characters
      for (int i = 0; i < 6; i++) begin
         rv = mk(7'($urandom_range(0, 127)), 9'($urandom_range(0, 170)), 9'($urandom_range(0, 135)),
                 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), $urandom_range(0, 3),
                 -1, -1, 1'b0, 88'h0, 1'b0, 32'h0);
         run_char(rv, 200 + i, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_show_char.md
LCD_SHOW_CHAR -- requirements
Module: lcd_show_char

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
 - H_RES, 160, panel width in pixels (landscape)
 - V_RES, 128, panel height in pixels
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
 - sys_clk  in  1  single clock
 - sys_rst_n  in  1  reset, synchronous, active-low
 - show_char_flag  in  1  one-cycle request to draw one character
 - ascii_num  in  7  font index, equal to ASCII minus 32 (0..94)
 - start_x  in  9  top-left x in pixels
 - start_y  in  9  top-left y in pixels
 - en_size  in  1  1 = 16x8 font, 0 = 12x6 font
 - background_color  in  16  RGB565 colour for 0 bits
 - front_color  in  16  RGB565 colour for 1 bits
 - rom_addr  out  11  font ROM address
 - rom_sel  out  1  font ROM select, mirrors latched en_size
 - rom_data  in  8  font row; MSB is the leftmost pixel; read latency 1 cycle
 - spi_wr_req  out  1  byte write request to the SPI byte writer
 - spi_wr_data  out  9  bit8 = D/C (0 command, 1 data); bits[7:0] = byte
 - spi_wr_ack  in  1  one-cycle pulse; the writer has accepted the current byte
 - busy  out  1  high from request acceptance until done
 - show_char_done  out  1  one-cycle pulse when the character is finished
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low (sys_clk, sys_rst_n).

Function
REQ-004 When show_char_flag=1 in IDLE, the block SHALL latch all character inputs and both colours, then assert busy on the next cycle.
REQ-005 A show_char_flag that arrives while busy=1 SHALL be ignored.
REQ-006 ascii_num>94 SHALL be replaced by 0 (space) at latch time.
REQ-007 Font geometry SHALL be: W=8, H=16 when en_size=1; W=6, H=12 when en_size=0.
REQ-008 Window end coordinates SHALL be xe=start_x+W-1 and ye=start_y+H-1, computed in 9 bits.
REQ-009 If start_x>=H_RES or start_y>=V_RES, the block SHALL send no bytes and SHALL pulse show_char_done 2 cycles after the request.
REQ-010 The state machine SHALL use the states IDLE, SET_WIN, FETCH, WAIT_ROM, PIX_HI, PIX_LO, DONE.
REQ-011 SET_WIN SHALL send 11 bytes in order:
 - cmd 0x2A, then data {7'b0,xs[8]}, xs[7:0], {7'b0,xe[8]}, xe[7:0]
 - cmd 0x2B, then the same four-byte pattern for y
 - cmd 0x2C
REQ-012 Write handshake:
 - spi_wr_req SHALL rise together with valid spi_wr_data.
 - spi_wr_req and spi_wr_data SHALL be held stable until the cycle spi_wr_ack=1 is sampled.
 - spi_wr_req SHALL drop in the following cycle.
 - The next request SHALL NOT be raised earlier than 1 cycle after the drop.
REQ-013 FETCH SHALL drive rom_addr as follows, and WAIT_ROM SHALL capture rom_data one cycle later into a row shift register:
 - en_size=1: ascii_num*16+row
 - en_size=0: ascii_num*12+row
REQ-014 Pixel colour selection:
 - Pixels SHALL be taken from row bits 7 down to 8-W, left to right.
 - A pixel SHALL use front_color when its bit is 1, else background_color.
REQ-015 Each pixel SHALL be sent as 2 data bytes: PIX_HI sends colour[15:8], PIX_LO sends colour[7:0].
REQ-016 After the last column of a row, the block SHALL return to FETCH for row+1; after row H-1, it SHALL enter DONE.
REQ-017 Byte totals per character SHALL be 11+2*W*H: 267 for 16x8 and 155 for 12x6.
REQ-018 DONE SHALL:
 - pulse show_char_done for 1 cycle, in the cycle after the final spi_wr_ack
 - deassert busy in that same cycle
 - return to IDLE
REQ-019 A new show_char_flag SHALL be accepted in the cycle immediately after the show_char_done pulse.
REQ-020 Column and row counters SHALL NOT wrap past W-1 or H-1.
REQ-021 An x or y window overflowing the panel edge (in range start, out-of-range end) SHALL be sent unclipped.

Reset
REQ-022 While sys_rst_n=0 at a sys_clk edge, all of the following SHALL hold:
 - state=IDLE
 - busy=0, show_char_done=0, spi_wr_req=0
 - spi_wr_data=0, rom_addr=0, rom_sel=0
 - all counters and latches cleared
REQ-023 Reset asserted mid-character SHALL abort immediately, with no show_char_done pulse.

Verification
REQ-024 The bench SHALL cover these scenarios:
 - Request 'K' (ascii_num=43), en_size=1, (48,0), spi_wr_ack 3 cycles after each request -> bytes 2A,00,30,00,37,2B,00,00,00,0F,2C then 256 pixel bytes matching the ROM; rom_addr runs 688..703; exactly one done pulse.
 - en_size=0, ascii_num=17, (0,32) -> window x 0..5, y 32..43; rom_addr 204..215; 155 bytes total.
 - Row 0xA0 with front_color=FFFF, background_color=AF7D -> first pixel bytes FF,FF, then AF,7D.
 - Second show_char_flag pulsed mid-character -> ignored; byte count unchanged.
 - start_x=160 -> no spi_wr_req; done pulse 2 cycles after the request.
 - Reset asserted at byte 100 -> outputs at reset values next cycle; a following request completes normally.
